// File: rtl/adder_pkg.sv
// Shared constants and configuration helpers for the pipelined adder.
// Holds the default operand/slice widths and the stage-count derivation.
package adder_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   function automatic int calcStages(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A split is usable only if every stage gets a full, non-empty slice.
   function automatic bit isLegalSplit(input int width, input int chunk);
      return (chunk > 0) && (width >= 4) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit adder with carry-in and carry-out; one per pipeline stage.
module adder_slice
   import adder_pkg::*;
#(
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             carryIn,
   output logic [CHUNK-1:0] sum,
   output logic             carryOut
);

   logic [CHUNK:0] total;

   assign total    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, carryIn};
   assign sum      = total[CHUNK-1:0];
   assign carryOut = total[CHUNK];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: each stage adds one CHUNK-bit slice behind a valid/ready stall chain.
// Defining PIPE_ADDER_OVF_EN adds the registered signed-overflow output ovf.
module pipe_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PIPE_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int STAGES = calcStages(WIDTH, CHUNK);
   localparam int LAST   = STAGES - 1;

   if (!isLegalSplit(WIDTH, CHUNK)) begin : gBadCfg
      $error("pipe_adder: WIDTH must be >= 4 and a multiple of CHUNK");
   end

   genvar gi;
   for (gi = 0; gi < STAGES; gi++) begin : stg
      localparam int DONE = (gi + 1) * CHUNK;

      logic [CHUNK-1:0] sliceA;
      logic [CHUNK-1:0] sliceB;
      logic [CHUNK-1:0] sliceSum;
      logic             carryIn;
      logic             carryOut;
      logic [DONE-1:0]  sumNext;
      logic [DONE-1:0]  sumReg;
      logic             carryReg;
      logic             validReg;
      logic             load;
      logic             drain;

      if (gi == 0) begin : gSrc
         assign sliceA  = a[CHUNK-1:0];
         assign sliceB  = b[CHUNK-1:0];
         assign carryIn = cin;
         assign sumNext = sliceSum;
         assign load    = in_valid && in_ready;
      end else begin : gSrc
         assign sliceA  = stg[gi-1].gFwd.aRem[CHUNK-1:0];
         assign sliceB  = stg[gi-1].gFwd.bRem[CHUNK-1:0];
         assign carryIn = stg[gi-1].carryReg;
         assign sumNext = {sliceSum, stg[gi-1].sumReg};
         assign load    = stg[gi-1].validReg && (!validReg || drain);
      end

      // A stage empties when its content moves on: into the next stage, or out of the block.
      if (gi == LAST) begin : gSink
         assign drain = validReg && out_ready;
      end else begin : gSink
         assign drain = stg[gi+1].load;
      end

      adder_slice #(
         .CHUNK(CHUNK)
      ) uSlice (
         .a        (sliceA),
         .b        (sliceB),
         .carryIn  (carryIn),
         .sum      (sliceSum),
         .carryOut (carryOut)
      );

      always_ff @(posedge clk) begin
         if (rst) begin
            validReg <= 1'b0;
            sumReg   <= '0;
            carryReg <= 1'b0;
         end else if (load) begin
            validReg <= 1'b1;
            sumReg   <= sumNext;
            carryReg <= carryOut;
         end else if (drain) begin
            validReg <= 1'b0;
         end
      end

      // Unconsumed operand bits shrink by one slice per stage; the last stage needs none.
      if (gi < LAST) begin : gFwd
         localparam int REM = WIDTH - DONE;

         logic [REM-1:0] aRem;
         logic [REM-1:0] bRem;
         logic [REM-1:0] aRemNext;
         logic [REM-1:0] bRemNext;

         if (gi == 0) begin : gPick
            assign aRemNext = a[WIDTH-1:DONE];
            assign bRemNext = b[WIDTH-1:DONE];
         end else begin : gPick
            assign aRemNext = stg[gi-1].gFwd.aRem[REM+CHUNK-1:CHUNK];
            assign bRemNext = stg[gi-1].gFwd.bRem[REM+CHUNK-1:CHUNK];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               aRem <= '0;
               bRem <= '0;
            end else if (load) begin
               aRem <= aRemNext;
               bRem <= bRemNext;
            end
         end
      end
   end

   assign in_ready  = !stg[0].validReg || stg[0].drain;
   assign out_valid = stg[LAST].validReg;
   assign sum       = stg[LAST].sumReg;
   assign cout      = stg[LAST].carryReg;

`ifdef PIPE_ADDER_OVF_EN
   logic ovfReg;

   // The top slice carries the operand MSBs, so overflow is judged where that slice is added.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovfReg <= 1'b0;
      end else if (stg[LAST].load) begin
         ovfReg <= (stg[LAST].sliceA[CHUNK-1] == stg[LAST].sliceB[CHUNK-1]) &&
                   (stg[LAST].sliceSum[CHUNK-1] != stg[LAST].sliceA[CHUNK-1]);
      end
   end

   assign ovf = ovfReg;
`endif

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
Parametrised, pipelined ripple-carry adder computing a + b + cin for WIDTH-bit operands.
- Operands are split into CHUNK-bit slices; each pipeline stage adds one slice and registers its carry for the next stage.
- Valid/ready handshakes on input and output. Sustained throughput: one addition per clock.
- Intended as the arithmetic datapath primitive for wider accumulators and ALU work in the exercises tree.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK, minimum 4.
CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK is a derived localparam, not overridable.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, cin valid this cycle
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
cin  input  1  carry-in to bit 0
out_valid  output  1  sum/cout valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  signed overflow (present only with PIPE_ADDER_OVF_EN)

Behaviour:
- Reset (rst=1 at clk edge): all stage valid bits cleared; out_valid=0, sum=0, cout=0, ovf=0. in_ready is not forced low during reset and follows the normal rule. Data registers may also be cleared.
- Reset mid-operation: every in-flight transaction is discarded; no partial result is ever presented.
- Stage k (0..STAGES-1) holds:
  - valid_k;
  - sum bits [k*CHUNK-1:0] already computed;
  - unconsumed operand bits [WIDTH-1:k*CHUNK] of a and b;
  - carry_k.
- Stage 0 computes slice 0 from a, b and cin. Stage k adds slice k of the forwarded operands plus the registered carry.
- Transfers:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - Stage k advances when valid_(k-1) && (!valid_k || stage k advances downstream); this is a standard stall chain.
  - in_ready = !valid_0 || stage 0 advancing. No combinational path from in_valid to in_ready.
- Latency: a transaction accepted at edge N presents out_valid=1 after edge N+STAGES-1 and holds it until taken.
- Back-pressure: with out_ready=0, out_valid, sum and cout stay stable. Upstream stages fill until all are valid, then in_ready=0. No data is lost or duplicated.
- Simultaneous accept and output transfer with a full pipe: every stage shifts, and throughput stays at 1/cycle.
- Arithmetic: each slice add is CHUNK+1 bits wide. The MSB becomes the next carry; the final stage's MSB is cout.
- Wrap-around: an all-ones + 1 result gives sum=0, cout=1.
- Order: results are delivered strictly in acceptance order.

Optional Feature:
Macro PIPE_ADDER_OVF_EN.
- Defined: ovf port exists, registered in the final stage as (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]). The operand MSBs are forwarded through the pipeline for this. ovf is valid with out_valid and reset to 0.
- Undefined: ovf port and its MSB forwarding logic are absent, and there is no area cost.

Decomposition:
- Shared package adder_pkg holds:
  - the default WIDTH and CHUNK constants;
  - the STAGES derivation function;
  - a WIDTH%CHUNK==0 legality check, flagged by an elaboration-time error.
- Sub-module adder_slice: a combinational CHUNK-bit adder with carry-in/carry-out, instantiated once per stage. It is the generalised full adder.
- Handshake/valid chain stays in pipe_adder.

Test Plan:
- WIDTH=16, CHUNK=4: a=0x1234, b=0x4321, cin=0, out_ready=1 -> after 3 further edges, out_valid=1, sum=0x5555, cout=0.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; the carry must ripple through all 4 stages.
- Stream 8 back-to-back random pairs with in_valid=1 and out_ready=1 -> in_ready stays 1, 8 consecutive correct results in order, no bubbles.
- Hold out_ready=0 while pushing 6 items -> in_ready drops after the 4th accept, output holds the first result stable; release out_ready -> all 6 results emerge in order.
- Assert rst for 1 cycle with 3 items in flight -> the next cycle has out_valid=0, in_ready=1, and no stale result appears afterwards.
- With PIPE_ADDER_OVF_EN: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0; a=0x8000, b=0x8000 -> sum=0x0000, ovf=1, cout=1.
